vc_arbiter_ctrl: RTL
====================

Name: vc_arbiter_ctrl

Overview:
Controller and arbiter sitting between the two virtual-channel FIFOs (VC0, VC1) and the two destination FIFOs (D0, D1) of the transmit path. It sequences the bring-up (reset, threshold configuration, idle, active) and distributes the FIFO thresholds. It arbitrates pops from VC0/VC1 and routes each popped word to D0 or D1 by its destination bit, under destination backpressure.

Parameters:
DATA_WIDTH, 6, word width of VC/D FIFO data
DEST_BIT, 4, index of the data bit selecting the destination (0 = D0, 1 = D1)
UMBRAL_WIDTH, 4, width of each threshold value

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
init  input  1  configuration request; high = load thresholds
umbral_vc0_in, umbral_vc1_in, umbral_d0_in, umbral_d1_in  input  UMBRAL_WIDTH each  thresholds to latch in INIT
empty_vc0, empty_vc1  input  1 each  VC FIFO empty flags
almost_full_d0, almost_full_d1  input  1 each  destination FIFO almost-full flags
data_vc0, data_vc1  input  DATA_WIDTH each  VC FIFO read data, valid the cycle after a pop
pop_vc0, pop_vc1  output  1 each  VC FIFO read enables (combinational)
push_d0, push_d1  output  1 each  destination FIFO write enables (registered)
data_out  output  DATA_WIDTH  word to destination FIFOs (registered)
umbral_vc0, umbral_vc1, umbral_d0, umbral_d1  output  UMBRAL_WIDTH each  latched thresholds
state  output  2  FSM state: 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE
idle  output  1  high when state == IDLE

Behaviour:
- Reset (reset == 0 at a clk edge): state = RESET. pop_*, push_*, data_out, all umbral_* and idle = 0. Pipeline flags are cleared. Reset overrides everything, including mid-transfer; in-flight words are dropped.
- FSM transitions:
  - RESET -> INIT when reset == 1.
  - INIT: each cycle, latch umbral_*_in into umbral_*. Stay while init == 1; go to IDLE when init == 0.
  - IDLE -> ACTIVE when empty_vc0 == 0 or empty_vc1 == 0.
  - ACTIVE -> IDLE when both VC FIFOs are empty and no word is in flight (both pipeline stages empty).
  - init == 1 in IDLE or ACTIVE -> INIT on the next edge. Pops stop immediately; in-flight words are discarded (no push); umbral_* are reloaded.
- Pop conditions:
  - Pops occur only in ACTIVE, and only when almost_full_d0 == 0 and almost_full_d1 == 0. Both are checked because the destination is unknown before the read.
  - At most one pop per cycle.
  - Default arbitration is strict priority: pop_vc0 = !empty_vc0. pop_vc1 = empty_vc0 & !empty_vc1.
- Pipeline:
  - Cycle t: pop asserted; the popped VC is registered as stage-1 select.
  - Cycle t+1: data_vcX is sampled into data_out.
  - Cycle t+2: data_out holds the word and exactly one push is high: push_d1 if data_out[DEST_BIT] == 1, else push_d0.
  - Latency is 2 cycles pop-to-push. Throughput is 1 word per cycle.
  - push_* are 0 in any cycle without a valid stage-2 word. data_out holds its last value.
- Backpressure: in-flight words (at most 2) always complete after almost_full asserts. Destination almost-full thresholds must therefore leave at least 2 free entries. This is the requirement on umbral_d*.
- The block never pops an empty FIFO. An empty flag rising in the same cycle is respected combinationally.

Optional Feature:
Macro: VC_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register (reset 1, so VC0 wins first) toggles to the granted VC on each pop.
  - When both VCs are non-empty, the VC not granted last wins. A single non-empty VC is always granted.
- Undefined: strict VC0 priority as above; no last-grant register.

Test Plan:
1. Reset low 2 cycles, then high with init = 1 and umbral_vc0_in = 3, umbral_d0_in = 12 -> state 0 then 1; umbral_vc0 = 3 and umbral_d0 = 12 one cycle after entering INIT; all pops and pushes 0.
2. init drops, VC0 holds 0x05 then 0x15 (DEST_BIT = 4) -> ACTIVE; pop_vc0 two consecutive cycles; push_d0 with data_out = 0x05 two cycles after the first pop; push_d1 with 0x15 the next cycle; return to IDLE after the last push.
3. Both VCs non-empty with 3 words each, macro undefined -> all VC0 words are popped before any pop_vc1. With VC_ARB_RR_EN -> grants alternate VC0, VC1, VC0, ...
4. almost_full_d1 rises the cycle after a pop -> no further pops; the 2 in-flight words are still pushed; popping resumes the cycle after almost_full_d1 falls.
5. init raised while 2 words are in flight -> next state INIT; no push occurs for the in-flight words; pops stay 0.
6. reset low during ACTIVE with words in flight -> state RESET next cycle; all outputs 0; no push is issued.

Source files
------------

// File: rtl/vc_arbiter_ctrl.sv
// Bring-up FSM and pop arbiter between two VC FIFOs and two destination FIFOs.
// Optional build macro VC_ARB_RR_EN selects round-robin arbitration instead of strict VC0 priority.
module vc_arbiter_ctrl #(
    parameter int DATA_WIDTH   = 6,
    parameter int DEST_BIT     = 4,
    parameter int UMBRAL_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [UMBRAL_WIDTH-1:0] umbral_vc0_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_vc1_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_d0_in,
    input  logic [UMBRAL_WIDTH-1:0] umbral_d1_in,
    input  logic                    empty_vc0,
    input  logic                    empty_vc1,
    input  logic                    almost_full_d0,
    input  logic                    almost_full_d1,
    input  logic [DATA_WIDTH-1:0]   data_vc0,
    input  logic [DATA_WIDTH-1:0]   data_vc1,
    output logic                    pop_vc0,
    output logic                    pop_vc1,
    output logic                    push_d0,
    output logic                    push_d1,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [UMBRAL_WIDTH-1:0] umbral_vc0,
    output logic [UMBRAL_WIDTH-1:0] umbral_vc1,
    output logic [UMBRAL_WIDTH-1:0] umbral_d0,
    output logic [UMBRAL_WIDTH-1:0] umbral_d1,
    output logic [1:0]              state,
    output logic                    idle
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    s1_valid;
    logic                    s1_sel;
    logic [DATA_WIDTH-1:0]   s1_word;
    logic                    can_pop;
    logic                    grant_vc0;
    logic                    grant_vc1;
    logic                    in_flight;

    assign state = state_r;
    assign idle  = (state_r == ST_IDLE);

    // Destination is unknown until the word is read, so both destinations must have room.
    assign can_pop = reset && !init && (state_r == ST_ACTIVE)
                     && !almost_full_d0 && !almost_full_d1;

`ifdef VC_ARB_RR_EN
    logic last_grant;

    assign grant_vc0 = !empty_vc0 && (empty_vc1 || last_grant);
    assign grant_vc1 = !empty_vc1 && (empty_vc0 || !last_grant);

    // last_grant == 1 means VC1 was served last, so VC0 wins the first contested pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (pop_vc0) begin
            last_grant <= 1'b0;
        end else if (pop_vc1) begin
            last_grant <= 1'b1;
        end
    end
`else
    assign grant_vc0 = !empty_vc0;
    assign grant_vc1 = empty_vc0 && !empty_vc1;
`endif

    assign pop_vc0 = can_pop && grant_vc0;
    assign pop_vc1 = can_pop && grant_vc1;

    assign s1_word   = s1_sel ? data_vc1 : data_vc0;
    assign in_flight = s1_valid || push_d0 || push_d1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_RESET;
            s1_valid   <= 1'b0;
            s1_sel     <= 1'b0;
            push_d0    <= 1'b0;
            push_d1    <= 1'b0;
            data_out   <= '0;
            umbral_vc0 <= '0;
            umbral_vc1 <= '0;
            umbral_d0  <= '0;
            umbral_d1  <= '0;
        end else begin
            // NOTE: defaults here are non-blocking too; a later branch assignment simply wins.
            s1_valid <= 1'b0;
            push_d0  <= 1'b0;
            push_d1  <= 1'b0;
            case (state_r)
                ST_RESET: state_r <= ST_INIT;
                ST_INIT: begin
                    umbral_vc0 <= umbral_vc0_in;
                    umbral_vc1 <= umbral_vc1_in;
                    umbral_d0  <= umbral_d0_in;
                    umbral_d1  <= umbral_d1_in;
                    if (!init) state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (init)                         state_r <= ST_INIT;
                    else if (!empty_vc0 || !empty_vc1) state_r <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // A config request discards every in-flight word.
                    if (init) begin
                        state_r <= ST_INIT;
                    end else begin
                        s1_valid <= pop_vc0 || pop_vc1;
                        s1_sel   <= pop_vc1;
                        if (s1_valid) begin
                            data_out <= s1_word;
                            push_d1  <= s1_word[DEST_BIT];
                            push_d0  <= !s1_word[DEST_BIT];
                        end
                        if (empty_vc0 && empty_vc1 && !in_flight) state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_RESET;
            endcase
        end
    end

endmodule
